// File: rtl/icache_fetch_ctrl.sv
// icache_fetch_ctrl: direct-mapped, one-word-per-line instruction cache with
// a single-request refill sequencer toward the memory controller.
// Optional next-line prefetch is compiled in when ICACHE_PREFETCH_EN is defined.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | serve hits, turn a miss into a refill
// S_REFILL   | pc_miss_sgn held for pc_out until finish_ins
// S_PREFETCH | (ICACHE_PREFETCH_EN) installing pc_out silently; hits still served
module icache_fetch_ctrl #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        fetch_sgn,
  input  logic [31:0] fetch_pc,
  output logic        fetch_hit,
  output logic [31:0] fetch_ins,
  output logic [31:0] pc_out,
  output logic        pc_miss_sgn,
  input  logic        finish_ins,
  input  logic [31:0] ins_in
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int NLINES   = 1 << INDEX_BITS;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REFILL   = 2'd1;
`ifdef ICACHE_PREFETCH_EN
  localparam logic [1:0] S_PREFETCH = 2'd2;
`endif

  logic [1:0]          r_state;
  logic [NLINES-1:0]   r_valid;
  logic [TAG_BITS-1:0] r_tag  [NLINES];
  logic [31:0]         r_data [NLINES];
  logic                r_fetch_hit;
  logic [31:0]         r_fetch_ins;
  logic [31:0]         r_pc_out;

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_hit;
  logic                  w_req;
  logic                  w_busy;
  logic                  w_fill;
  logic [INDEX_BITS-1:0] w_fill_idx;
  logic [TAG_BITS-1:0]   w_fill_tag;
  logic                  w_unused;

  // Lookup of the requested line; the byte offset never matters for words.
  assign w_idx    = fetch_pc[INDEX_BITS+1:2];
  assign w_tag    = fetch_pc[31:INDEX_BITS+2];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused = ^fetch_pc[1:0];

  // A request is not re-sampled while its answer is still on fetch_hit.
  assign w_req = fetch_sgn && !r_fetch_hit;

`ifdef ICACHE_PREFETCH_EN
  assign w_busy = (r_state == S_REFILL) || (r_state == S_PREFETCH);
`else
  assign w_busy = (r_state == S_REFILL);
`endif

  // Request drops in the finish cycle so the controller never sees a stale one.
  assign pc_miss_sgn = w_busy && !finish_ins && !rollback;

  assign w_fill     = rdy && !rollback && finish_ins && w_busy;
  assign w_fill_idx = r_pc_out[INDEX_BITS+1:2];
  assign w_fill_tag = r_pc_out[31:INDEX_BITS+2];

`ifdef ICACHE_PREFETCH_EN
  logic [31:0]           w_nxt_pc;
  logic [INDEX_BITS-1:0] w_nxt_idx;
  logic                  w_nxt_hit;

  // Next sequential line; 32-bit add wraps 0xFFFFFFFC to 0 on its own.
  assign w_nxt_pc  = r_pc_out + 32'd4;
  assign w_nxt_idx = w_nxt_pc[INDEX_BITS+1:2];
  assign w_nxt_hit = r_valid[w_nxt_idx] && (r_tag[w_nxt_idx] == w_nxt_pc[31:INDEX_BITS+2]);
`endif

  // Valid bits: only reset clears them; a fill always overwrites the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_fill) begin
      r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset because valid gates every use.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= ins_in;
    end
  end

  // Sequencer: hit service, refill, optional prefetch, rollback squash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_fetch_hit <= 1'b0;
      r_fetch_ins <= '0;
      r_pc_out    <= '0;
    end else if (rdy) begin
      r_fetch_hit <= 1'b0;
      if (rollback) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_req) begin
              if (w_hit) begin
                r_fetch_ins <= r_data[w_idx];
                r_fetch_hit <= 1'b1;
              end else begin
                r_pc_out <= {fetch_pc[31:2], 2'b00};
                r_state  <= S_REFILL;
              end
            end
          end
          S_REFILL: begin
            if (finish_ins) begin
              r_fetch_ins <= ins_in;
              r_fetch_hit <= 1'b1;
`ifdef ICACHE_PREFETCH_EN
              if (!w_nxt_hit) begin
                r_pc_out <= w_nxt_pc;
                r_state  <= S_PREFETCH;
              end else begin
                r_state <= S_IDLE;
              end
`else
              r_state <= S_IDLE;
`endif
            end
          end
`ifdef ICACHE_PREFETCH_EN
          S_PREFETCH: begin
            // Misses wait (fetch_sgn is level); hits are answered meanwhile.
            if (w_req && w_hit) begin
              r_fetch_ins <= r_data[w_idx];
              r_fetch_hit <= 1'b1;
            end
            if (finish_ins) begin
              r_state <= S_IDLE;
            end
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign fetch_hit = r_fetch_hit;
  assign fetch_ins = r_fetch_ins;
  assign pc_out    = r_pc_out;

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Directed bench for icache_fetch_ctrl with an expected-instruction scoreboard
// and request/hit counters watching the handshakes.
module tb_icache_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback, fetch_sgn, finish_ins;
  logic [31:0] fetch_pc, ins_in;
  logic        fetch_hit, pc_miss_sgn;
  logic [31:0] fetch_ins, pc_out;

  int n_pass = 0;
  int n_fail = 0;
  int req_cnt = 0;
  int exp_req = 0;
  int hit_cnt = 0;
  int exp_hits = 0;
  logic prev_miss = 1'b0;
  logic [31:0] exp_q[$];

  icache_fetch_ctrl #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .fetch_sgn(fetch_sgn), .fetch_pc(fetch_pc),
    .fetch_hit(fetch_hit), .fetch_ins(fetch_ins),
    .pc_out(pc_out), .pc_miss_sgn(pc_miss_sgn),
    .finish_ins(finish_ins), .ins_in(ins_in)
  );

  always #5 clk = ~clk;

  // Memory-side view: each new rise of the request is one request.
  always @(negedge clk) begin
    if (rst) prev_miss = 1'b0;
    else if (rdy) begin
      if (pc_miss_sgn && !prev_miss) req_cnt++;
      prev_miss = pc_miss_sgn;
    end
  end

  // Fetch-side view: a hit is consumed on the first un-stalled edge.
  always @(negedge clk) begin
    if (!rst && rdy && fetch_hit) hit_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic take_hit;
    logic [31:0] e;
    chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sb_ins", fetch_ins, e);
      exp_hits++;
    end
  endtask

  task automatic fetch_expect_hit(input logic [31:0] addr, input logic [31:0] exp);
    fetch_pc = addr; fetch_sgn = 1'b1; exp_q.push_back(exp);
    tick;
    chk("hit_lat", {31'd0, fetch_hit}, 32'd1);
    chk("hit_no_req", {31'd0, pc_miss_sgn}, 32'd0);
    take_hit();
    fetch_sgn = 1'b0;
    tick;
    chk("hit_pulse", {31'd0, fetch_hit}, 32'd0);
  endtask

  task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] data, input int lat);
    logic held;
    logic [31:0] a;
    a = {addr[31:2], 2'b00};
    fetch_pc = addr; fetch_sgn = 1'b1; exp_q.push_back(data);
    exp_req++;
    tick;
    chk("miss_req", {31'd0, pc_miss_sgn}, 32'd1);
    chk("miss_pc", pc_out, a);
    chk("miss_nohit", {31'd0, fetch_hit}, 32'd0);
    held = 1'b1;
    for (int i = 1; i < lat; i++) begin
      tick;
      if (pc_miss_sgn !== 1'b1 || pc_out !== a || fetch_hit !== 1'b0) held = 1'b0;
    end
    chk("miss_held", {31'd0, held}, 32'd1);
    tick;
    finish_ins = 1'b1; ins_in = data;
    #1;
    chk("miss_drop", {31'd0, pc_miss_sgn}, 32'd0);
    tick;
    finish_ins = 1'b0; ins_in = '0;
    chk("refill_hit", {31'd0, fetch_hit}, 32'd1);
    take_hit();
    fetch_sgn = 1'b0;
`ifdef ICACHE_PREFETCH_EN
    if (pc_miss_sgn === 1'b1) begin
      exp_req++;
      chk("pf_pc", pc_out, a + 32'd4);
      tick;
      finish_ins = 1'b1; ins_in = mem_word(a + 32'd4);
      tick;
      finish_ins = 1'b0; ins_in = '0;
      chk("pf_nohit", {31'd0, fetch_hit}, 32'd0);
      chk("pf_done", {31'd0, pc_miss_sgn}, 32'd0);
    end else begin
      tick;
    end
`else
    tick;
`endif
    chk("refill_pulse", {31'd0, fetch_hit}, 32'd0);
  endtask

  initial begin
    logic held;
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; fetch_sgn = 1'b0;
    fetch_pc = '0; finish_ins = 1'b0; ins_in = '0;
    repeat (2) tick;
    chk("rst_hit", {31'd0, fetch_hit}, 32'd0);
    chk("rst_ins", fetch_ins, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_req", {31'd0, pc_miss_sgn}, 32'd0);
    rst = 1'b0;
    tick;
    chk("idle_req", {31'd0, pc_miss_sgn}, 32'd0);

    // Cold miss, then a one-cycle hit on the same address.
    fetch_miss(32'h0000_0000, 32'h0000_0013, 10);
    fetch_expect_hit(32'h0000_0000, 32'h0000_0013);

    // Index collision: 0x100 evicts 0x0, which then misses again.
    fetch_miss(32'h0000_0100, 32'hAAAA_0100, 3);
    fetch_expect_hit(32'h0000_0100, 32'hAAAA_0100);
    fetch_miss(32'h0000_0000, 32'h0000_0013, 2);

    // Other indices, top of memory, and ignored offset bits.
    fetch_miss(32'h0000_0008, 32'h1111_2222, 1);
    fetch_miss(32'hFFFF_FFFC, 32'h55AA_55AA, 4);
    fetch_expect_hit(32'h0000_000B, 32'h1111_2222);
    fetch_expect_hit(32'hFFFF_FFFC, 32'h55AA_55AA);
    fetch_expect_hit(32'h0000_0000, 32'h0000_0013);

    // Rollback mid-refill without finish: pc_out keeps its value.
    fetch_pc = 32'h0000_0020; fetch_sgn = 1'b1; exp_req++;
    tick;
    chk("rb1_req", {31'd0, pc_miss_sgn}, 32'd1);
    tick;
    rollback = 1'b1;
    #1;
    chk("rb1_req_drop", {31'd0, pc_miss_sgn}, 32'd0);
    tick;
    rollback = 1'b0; fetch_sgn = 1'b0;
    chk("rb1_pc_kept", pc_out, 32'h0000_0020);
    chk("rb1_idle", {31'd0, pc_miss_sgn}, 32'd0);
    chk("rb1_nohit", {31'd0, fetch_hit}, 32'd0);

    // Rollback in the finish cycle: word discarded, request during rollback ignored.
    fetch_pc = 32'h0000_0020; fetch_sgn = 1'b1; exp_req++;
    tick;
    chk("rb2_req", {31'd0, pc_miss_sgn}, 32'd1);
    repeat (3) tick;
    fetch_pc = 32'h0000_0000;
    finish_ins = 1'b1; ins_in = 32'hDEAD_BEEF; rollback = 1'b1;
    #1;
    chk("rb2_req_drop", {31'd0, pc_miss_sgn}, 32'd0);
    tick;
    finish_ins = 1'b0; ins_in = '0; rollback = 1'b0; fetch_sgn = 1'b0;
    chk("rb2_nohit", {31'd0, fetch_hit}, 32'd0);
    chk("rb2_idle", {31'd0, pc_miss_sgn}, 32'd0);
    tick;
    chk("rb2_nohit2", {31'd0, fetch_hit}, 32'd0);
    fetch_miss(32'h0000_0020, 32'h1234_5678, 4);

    // Stall during a hit response.
    fetch_pc = 32'h0000_0000; fetch_sgn = 1'b1; exp_q.push_back(32'h0000_0013);
    tick;
    rdy = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (fetch_hit !== 1'b1 || fetch_ins !== 32'h0000_0013) held = 1'b0;
    end
    chk("stall_held", {31'd0, held}, 32'd1);
    rdy = 1'b1;
    take_hit();
    fetch_sgn = 1'b0;
    tick;
    chk("stall_pulse", {31'd0, fetch_hit}, 32'd0);

`ifdef ICACHE_PREFETCH_EN
    fetch_miss(32'h0000_0040, 32'h0000_4040, 3);
    fetch_expect_hit(32'h0000_0044, mem_word(32'h0000_0044));
`endif

    tick;
    chk("req_count", req_cnt, exp_req);
    chk("hit_count", hit_cnt, exp_hits);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
